mem_resp_buffer: RTL

Parametrised memory-stage buffer between EXE and WB for a data-SRAM interface that allows several outstanding requests. It holds up to DEPTH in-order instructions, matches in-order `data_ok` responses to the oldest memory entry still waiting, and performs MIPS load extraction (lb/lbu/lh/lhu/lw/lwl/lwr) with per-byte register write enables. On exception, eret or TLB flush it drops every entry and counts the responses still owed, so late `data_ok` beats are discarded instead of landing on younger instructions.

---
 rtl/mem_resp_buffer_if.sv | 39 +++
 rtl/mem_resp_buffer.sv | 132 +++++++++++++
 2 files changed

// File: rtl/mem_resp_buffer_if.sv
// EXE -> memory-stage buffer -> WB handshake bundle, including the data-SRAM response beat.
interface mem_resp_buffer_if #(
    parameter int INFO_W = 64,
    parameter int CW     = 3
);
    logic              in_valid;
    logic              in_allowin;
    logic              in_is_mem;
    logic              in_is_load;
    logic [6:0]        in_load_op;
    logic [1:0]        in_addr_lo;
    logic              in_gr_we;
    logic [31:0]       in_alu_result;
    logic [INFO_W-1:0] in_info;
    logic              data_ok;
    logic [31:0]       rdata;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [3:0]        out_rf_we;
    logic [31:0]       out_result;
    logic [INFO_W-1:0] out_info;
    logic              load_pending;
    logic [CW-1:0]     outstanding;

    modport master (
        output in_valid, in_is_mem, in_is_load, in_load_op, in_addr_lo, in_gr_we,
               in_alu_result, in_info, data_ok, rdata, flush, out_ready,
        input  in_allowin, out_valid, out_rf_we, out_result, out_info, load_pending,
               outstanding
    );

    modport slave (
        input  in_valid, in_is_mem, in_is_load, in_load_op, in_addr_lo, in_gr_we,
               in_alu_result, in_info, data_ok, rdata, flush, out_ready,
        output in_allowin, out_valid, out_rf_we, out_result, out_info, load_pending,
               outstanding
    );
endinterface

// File: rtl/mem_resp_buffer.sv
// In-order memory-stage buffer: matches in-order data_ok beats to waiting entries, extracts
// MIPS load results, and discards responses still owed by flushed instructions.
module mem_resp_buffer #(
    parameter int DEPTH  = 4,
    parameter int INFO_W = 64,
    parameter int CW     = $clog2(DEPTH + 1)
) (
    input logic              clk,
    input logic              resetn,
    mem_resp_buffer_if.slave bus
);
    localparam int PW = $clog2(DEPTH);

    logic [DEPTH-1:0]  valid;
    logic [DEPTH-1:0]  done;
    logic [DEPTH-1:0]  is_mem;
    logic [DEPTH-1:0]  is_load;
    logic [DEPTH-1:0]  gr_we;
    logic [6:0]        load_op [DEPTH];
    logic [1:0]        addr_lo [DEPTH];
    logic [31:0]       result  [DEPTH];
    logic [3:0]        rf_we   [DEPTH];
    logic [INFO_W-1:0] info    [DEPTH];

    logic [PW-1:0] head, tail, tgt, idx;
    logic [CW-1:0] count, discard_cnt, pending_mem, outstanding;
    logic          found, allowin, push, pop, resp, out_valid;
    logic [35:0]   ext;

    // Returns {rf_we, result} for a load response.
    function automatic logic [35:0] load_extract(input logic [6:0] op, input logic [1:0] a,
                                                 input logic [31:0] d, input logic we);
        logic [7:0]  b;
        logic [15:0] h;
        logic [4:0]  sh_l, sh_r;
        b    = d[{a, 3'b000} +: 8];
        h    = a[1] ? d[31:16] : d[15:0];
        sh_l = {~a, 3'b000};
        sh_r = {a, 3'b000};
        load_extract = {{4{we}}, d};
        if (op[1])      load_extract = {{4{we}}, {{24{b[7]}}, b}};
        else if (op[2]) load_extract = {{4{we}}, {24'h0, b}};
        else if (op[3]) load_extract = {{4{we}}, {{16{h[15]}}, h}};
        else if (op[4]) load_extract = {{4{we}}, {16'h0, h}};
        else if (op[5]) load_extract = {4'b1111 << ~a, d << sh_l};
        else if (op[6]) load_extract = {4'b1111 >> a, d >> sh_r};
    endfunction

    // Oldest waiting memory entry, searched from head.
    always_comb begin
        pending_mem = '0;
        found       = 1'b0;
        tgt         = '0;
        idx         = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] & is_mem[i] & ~done[i]) pending_mem = pending_mem + CW'(1);
            idx = head + PW'(i);
            if (!found && valid[idx] && is_mem[idx] && !done[idx]) begin
                found = 1'b1;
                tgt   = idx;
            end
        end
    end

    assign outstanding = pending_mem + discard_cnt;
    assign allowin     = (count < CW'(DEPTH)) && (outstanding < CW'(DEPTH));
    assign push        = bus.in_valid & allowin;
    assign resp        = bus.data_ok & (outstanding != '0);
    assign out_valid   = (count != '0) & done[head] & ~bus.flush;
    assign pop         = out_valid & bus.out_ready;
    assign ext         = load_extract(load_op[tgt], addr_lo[tgt], bus.rdata, gr_we[tgt]);

    assign bus.in_allowin   = allowin;
    assign bus.out_valid    = out_valid;
    assign bus.out_result   = out_valid ? result[head] : '0;
    assign bus.out_rf_we    = out_valid ? rf_we[head] : '0;
    assign bus.out_info     = out_valid ? info[head] : '0;
    assign bus.load_pending = |(valid & is_mem & is_load & ~done);
    assign bus.outstanding  = outstanding;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            discard_cnt <= '0;
            valid       <= '0;
            done        <= '0;
        end else if (bus.flush) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            valid       <= '0;
            done        <= '0;
            discard_cnt <= discard_cnt + pending_mem + CW'(push & bus.in_is_mem) - CW'(resp);
        end else begin
            if (resp) begin
                if (discard_cnt != '0) discard_cnt <= discard_cnt - CW'(1);
                else if (found)        done[tgt]   <= 1'b1;
            end
            if (pop) begin
                valid[head] <= 1'b0;
                done[head]  <= 1'b0;
                head        <= head + PW'(1);
            end
            if (push) begin
                valid[tail] <= 1'b1;
                done[tail]  <= ~bus.in_is_mem;
                tail        <= tail + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Entry payload carries no reset; it is qualified by valid/done.
    always_ff @(posedge clk) begin
        if (push & ~bus.flush) begin
            is_mem[tail]  <= bus.in_is_mem;
            is_load[tail] <= bus.in_is_load;
            gr_we[tail]   <= bus.in_gr_we;
            load_op[tail] <= bus.in_load_op;
            addr_lo[tail] <= bus.in_addr_lo;
            result[tail]  <= bus.in_alu_result;
            rf_we[tail]   <= bus.in_is_mem ? 4'b0000 : {4{bus.in_gr_we}};
            info[tail]    <= bus.in_info;
        end
        if (resp & ~bus.flush & (discard_cnt == '0) & found & is_load[tgt]) begin
            result[tgt] <= ext[31:0];
            rf_we[tgt]  <= ext[35:32];
        end
    end
endmodule
